// File: rtl/br_wr_arb.sv
// br_wr_arb: write-port arbiter for the 32x32 register bank.
// Three one-entry slots (writeback, jump-link, flag) share one registered write
// channel (ew/wa/wd/wf); hazard/fl_hazard flag pending writes for the stall logic.
// Ports: clk, rst (async, active high); wb_*, jl_*, fl_* request/ready pairs;
// rd_addr_a/b hazard probes; hazard, fl_hazard; ew, wa, wd, wf bank write bus.
// Build option: define BR_ARB_FIXPRI_EN for fixed priority wb > jl > fl
// (the round-robin pointer then disappears).
module br_wr_arb #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int JADDR = 31
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          wb_ready,
    input  logic          jl_valid,
    input  logic [DW-1:0] jl_data,
    output logic          jl_ready,
    input  logic          fl_valid,
    input  logic          fl_data,
    output logic          fl_ready,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic          hazard,
    output logic          fl_hazard,
    output logic [1:0]    ew,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd,
    output logic          wf
);

    localparam logic [AW-1:0] JA = AW'(JADDR);

    logic          s0_v;
    logic [AW-1:0] s0_a;
    logic [DW-1:0] s0_d;
    logic          s1_v;
    logic [DW-1:0] s1_d;
    logic          s2_v;
    logic          s2_d;

    // one-hot grant, computed from slots valid before the edge
    logic [2:0]    gnt;

`ifdef BR_ARB_FIXPRI_EN
    always_comb begin
        gnt = 3'b000;
        if (s0_v)      gnt = 3'b001;
        else if (s1_v) gnt = 3'b010;
        else if (s2_v) gnt = 3'b100;
    end
`else
    logic [1:0] ptr;

    // search starts just after the last winner
    always_comb begin
        gnt = 3'b000;
        case (ptr)
            2'd0: begin
                if (s1_v)      gnt = 3'b010;
                else if (s2_v) gnt = 3'b100;
                else if (s0_v) gnt = 3'b001;
            end
            2'd1: begin
                if (s2_v)      gnt = 3'b100;
                else if (s0_v) gnt = 3'b001;
                else if (s1_v) gnt = 3'b010;
            end
            default: begin
                if (s0_v)      gnt = 3'b001;
                else if (s1_v) gnt = 3'b010;
                else if (s2_v) gnt = 3'b100;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 2'd2;
        end else if (gnt[0]) begin
            ptr <= 2'd0;
        end else if (gnt[1]) begin
            ptr <= 2'd1;
        end else if (gnt[2]) begin
            ptr <= 2'd2;
        end
    end
`endif

    assign wb_ready = !s0_v;
    assign jl_ready = !s1_v;
    assign fl_ready = !s2_v;

    // the write currently on ew commits before the next edge, so only
    // slot contents count as hazards
    assign hazard = (s0_v && (s0_a != '0) &&
                     ((s0_a == rd_addr_a) || (s0_a == rd_addr_b))) ||
                    (s1_v && ((JA == rd_addr_a) || (JA == rd_addr_b)));
    assign fl_hazard = s2_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_v <= 1'b0;
            s0_a <= '0;
            s0_d <= '0;
            s1_v <= 1'b0;
            s1_d <= '0;
            s2_v <= 1'b0;
            s2_d <= 1'b0;
            ew   <= 2'b00;
            wa   <= '0;
            wd   <= '0;
            wf   <= 1'b0;
        end else begin
            ew <= 2'b00;
            if (gnt[0]) begin
                s0_v <= 1'b0;
                // r0 is hardwired: drop the write but still consume the slot
                if (s0_a != '0) begin
                    ew <= 2'b11;
                    wa <= s0_a;
                    wd <= s0_d;
                end
            end
            if (gnt[1]) begin
                s1_v <= 1'b0;
                ew   <= 2'b10;
                wa   <= JA;
                wd   <= s1_d;
            end
            if (gnt[2]) begin
                s2_v <= 1'b0;
                ew   <= 2'b01;
                wf   <= s2_d;
            end
            // a granted slot was full, so it cannot also load this edge
            if (wb_valid && !s0_v) begin
                s0_v <= 1'b1;
                s0_a <= wb_addr;
                s0_d <= wb_data;
            end
            if (jl_valid && !s1_v) begin
                s1_v <= 1'b1;
                s1_d <= jl_data;
            end
            if (fl_valid && !s2_v) begin
                s2_v <= 1'b1;
                s2_d <= fl_data;
            end
        end
    end

endmodule

// File: tb/tb_br_wr_arb.sv
// tb_br_wr_arb: randomized scoreboard bench for br_wr_arb.
// A slot-level reference model predicts bank writes; a negedge monitor checks them.
module tb_br_wr_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        wb_ready;
    logic        jl_valid = 1'b0;
    logic [31:0] jl_data = '0;
    logic        jl_ready;
    logic        fl_valid = 1'b0;
    logic        fl_data = 1'b0;
    logic        fl_ready;
    logic [4:0]  rd_addr_a = '0;
    logic [4:0]  rd_addr_b = '0;
    logic        hazard;
    logic        fl_hazard;
    logic [1:0]  ew;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        wf;

    br_wr_arb #(.AW(5), .DW(32), .JADDR(31)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_ready(wb_ready),
        .jl_valid(jl_valid), .jl_data(jl_data), .jl_ready(jl_ready),
        .fl_valid(fl_valid), .fl_data(fl_data), .fl_ready(fl_ready),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .hazard(hazard), .fl_hazard(fl_hazard),
        .ew(ew), .wa(wa), .wd(wd), .wf(wf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stamp;
        logic [1:0]  ew;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        wf;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int ecount = 0;

    // reference model: slot contents, last winner, last bank bus values
    bit          m_v[3];
    logic [4:0]  m_a;
    logic [31:0] m_d0, m_d1;
    logic        m_f;
    int          last;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic        m_wf;
    bit          acc[3];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_v[i] = 0;
        m_a = '0; m_d0 = '0; m_d1 = '0; m_f = 1'b0;
        last = 2;
        m_wa = '0; m_wd = '0; m_wf = 1'b0;
    endtask

    task automatic push(logic [1:0] e);
        exp_t x;
        x.stamp = ecount; x.ew = e; x.wa = m_wa; x.wd = m_wd; x.wf = m_wf;
        q.push_back(x);
    endtask

    // one clock edge of the reference model
    task automatic model_step();
        bit pre[3];
        int win;
        for (int i = 0; i < 3; i++) pre[i] = m_v[i];
        win = -1;
`ifdef BR_ARB_FIXPRI_EN
        for (int s = 0; s < 3; s++)
            if (pre[s] && win < 0) win = s;
`else
        for (int k = 1; k <= 3; k++)
            if (pre[(last + k) % 3] && win < 0) win = (last + k) % 3;
        if (win >= 0) last = win;
`endif
        ecount++;
        if (win == 0) begin
            m_v[0] = 0;
            if (m_a != 0) begin
                m_wa = m_a; m_wd = m_d0; push(2'b11);
            end
        end else if (win == 1) begin
            m_v[1] = 0; m_wa = 5'd31; m_wd = m_d1; push(2'b10);
        end else if (win == 2) begin
            m_v[2] = 0; m_wf = m_f; push(2'b01);
        end
        acc[0] = wb_valid && !pre[0];
        acc[1] = jl_valid && !pre[1];
        acc[2] = fl_valid && !pre[2];
        if (acc[0]) begin m_v[0] = 1; m_a = wb_addr; m_d0 = wb_data; end
        if (acc[1]) begin m_v[1] = 1; m_d1 = jl_data; end
        if (acc[2]) begin m_v[2] = 1; m_f = fl_data; end
    endtask

    function automatic bit model_hazard();
        return (m_v[0] && m_a != 0 && (m_a == rd_addr_a || m_a == rd_addr_b)) ||
               (m_v[1] && (rd_addr_a == 5'd31 || rd_addr_b == 5'd31));
    endfunction

    task automatic drive(bit wv, logic [4:0] wad, logic [31:0] wdt,
                         bit jv, logic [31:0] jd, bit fv, bit fd,
                         logic [4:0] ra, logic [4:0] rb);
        @(negedge clk);
        wb_valid = wv; wb_addr = wad; wb_data = wdt;
        jl_valid = jv; jl_data = jd;
        fl_valid = fv; fl_data = fd;
        rd_addr_a = ra; rd_addr_b = rb;
        #1;
        check("wb_ready", wb_ready, !m_v[0]);
        check("jl_ready", jl_ready, !m_v[1]);
        check("fl_ready", fl_ready, !m_v[2]);
        check("hazard", hazard, model_hazard());
        check("fl_hazard", fl_hazard, m_v[2]);
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(int n, logic [4:0] ra, logic [4:0] rb);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, ra, rb);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ew != 2'b00) begin
            if (q.size() == 0) begin
                tests++; fails++;
                $display("FAIL extra_write: got ew=%0b expected none", ew);
            end else begin
                e = q.pop_front();
                check("write_edge", 64'(ecount), 64'(e.stamp));
                check("ew", ew, e.ew);
                check("wa", wa, e.wa);
                check("wd", wd, e.wd);
                check("wf", wf, e.wf);
            end
        end
    end

    initial begin
        bit wv, jv, fv, fd;
        logic [4:0] wad, ra, rb;
        logic [31:0] wdt, jd;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        check("rst_ew", ew, 2'b00);
        check("rst_wa", wa, 5'd0);
        check("rst_wd", wd, 32'd0);
        check("rst_wf", wf, 1'b0);
        check("rst_readies", {wb_ready, jl_ready, fl_ready}, 3'b111);
        check("rst_hazard", {hazard, fl_hazard}, 2'b00);

        // all three at once: grants 11, 10, 01 from the reset pointer
        drive(1, 5'd3, 32'hA, 1, 32'hB, 1, 1, 0, 0);
        idle(4, 0, 0);
        // single writeback
        drive(1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 0);
        idle(3, 0, 0);
        // r0 write dropped, then r7 hazard
        drive(1, 5'd0, 32'hDEAD, 0, 0, 0, 0, 0, 0);
        idle(2, 0, 0);
        drive(1, 5'd7, 32'h77, 0, 0, 0, 0, 0, 5'd7);
        idle(3, 0, 5'd7);
        // jump-link and flag hazards
        drive(0, 0, 0, 1, 32'h4444, 1, 0, 5'd31, 0);
        idle(4, 5'd31, 0);
        // writeback to JADDR with jump-link pending
        drive(1, 5'd31, 32'h5555, 1, 32'h6666, 0, 0, 5'd31, 5'd31);
        idle(4, 5'd31, 5'd31);
        // source 0 re-requesting continuously alongside the flag
        for (int i = 0; i < 10; i++)
            drive(1, 5'(i + 1), 32'(i * 3), 0, 0, 1, i[0], 0, 0);
        idle(4, 0, 0);

        // randomized traffic honouring the hold-until-ready rule
        wv = 0; jv = 0; fv = 0; fd = 0; wad = 0; wdt = 0; jd = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!(wv && !acc[0])) begin
                wv = ($urandom_range(0, 99) < 60);
                wad = 5'($urandom_range(0, 31));
                wdt = $urandom;
            end
            if (!(jv && !acc[1])) begin
                jv = ($urandom_range(0, 99) < 35);
                jd = $urandom;
            end
            if (!(fv && !acc[2])) begin
                fv = ($urandom_range(0, 99) < 35);
                fd = 1'($urandom_range(0, 1));
            end
            ra = ($urandom_range(0, 3) == 0) ? m_a : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            drive(wv, wad, wdt, jv, jd, fv, fd, ra, rb);
        end
        idle(4, 0, 0);

        // async reset mid-cycle with slots full and a write on the bus
        drive(1, 5'd9, 32'h99, 1, 32'h98, 1, 1, 0, 0);
        drive(1, 5'd10, 32'h9A, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        wb_valid = 0; jl_valid = 0; fl_valid = 0;
        rd_addr_a = 5'd10; rd_addr_b = 5'd31;
        #1;
        check("mid_rst_readies", {wb_ready, jl_ready, fl_ready}, 3'b111);
        check("mid_rst_ew", ew, 2'b00);
        check("mid_rst_hazard", {hazard, fl_hazard}, 2'b00);
        q.delete();
        model_reset();
        #1 rst = 1'b0;
        drive(0, 0, 0, 1, 32'hCAFE, 0, 0, 0, 0);
        drive(1, 5'd12, 32'hBEEF, 0, 0, 0, 0, 0, 0);
        idle(4, 0, 0);

        check("queue_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
